// File: rtl/pe_cell_apb_pkg.sv
// Shared types for the pe_cell APB initiator.
// State encoding, command/response bundles, default widths.
package pe_cell_apb_pkg;

  localparam int DEF_WID_BUS  = 32;
  localparam int DEF_WID_ADDR = 8;
  localparam int DEF_TIMEOUT  = 16;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } apb_state_e;

  typedef struct packed {
    logic                    write;
    logic [DEF_WID_ADDR-1:0] addr;
    logic [DEF_WID_BUS-1:0]  wdata;
  } apb_cmd_t;

  typedef struct packed {
    logic [DEF_WID_BUS-1:0] rdata;
    logic                   err;
  } apb_rsp_t;

endpackage

// File: rtl/pe_cell_apb_master_if.sv
// Command/response channels and APB bus of the pe_cell initiator.
// master: the initiator block; slave: host plus APB target side.
interface pe_cell_apb_master_if
  import pe_cell_apb_pkg::*;
#(
  parameter int WID_BUS  = DEF_WID_BUS,
  parameter int WID_ADDR = DEF_WID_ADDR
) ();

  logic                cmd_valid;
  logic                cmd_ready;
  logic                cmd_write;
  logic [WID_ADDR-1:0] cmd_addr;
  logic [WID_BUS-1:0]  cmd_wdata;

  logic                rsp_valid;
  logic                rsp_ready;
  logic [WID_BUS-1:0]  rsp_rdata;
  logic                rsp_err;

  logic                psel;
  logic                penable;
  logic                pwrite;
  logic [WID_ADDR-1:0] paddr;
  logic [WID_BUS-1:0]  pwdata;
  logic [WID_BUS-1:0]  prdata;
  logic                pready;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    input  rsp_ready,
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    output rsp_ready,
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready
  );

endinterface

// File: rtl/pe_cell_apb_master.sv
// APB initiator for the pe_cell register port.
// One command at a time, wait states bounded by a timeout.
module pe_cell_apb_master
  import pe_cell_apb_pkg::*;
#(
  parameter int WID_BUS  = DEF_WID_BUS,
  parameter int WID_ADDR = DEF_WID_ADDR,
  parameter int TIMEOUT  = DEF_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pe_cell_apb_master_if.master bus,
  output logic                 busy
);

  localparam int CW =
    (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_SAT  = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_LAST =
    CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  apb_state_e          state_q, state_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic [WID_ADDR-1:0] paddr_q, paddr_d;
  logic [WID_BUS-1:0]  pwdata_q, pwdata_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_err_q, rsp_err_d;
  logic [WID_BUS-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic [CW-1:0]       cnt_q, cnt_d;

  // State, bus and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      cmd_ready_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      cmd_ready_q <= cmd_ready_d;
      cnt_q       <= cnt_d;
    end
  end

  // Next state: SETUP, ACCESS with wait/timeout, RESP.
  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    cmd_ready_d = cmd_ready_q;
    cnt_d       = cnt_q;
    unique case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        if (bus.cmd_valid && cmd_ready_q) begin
          paddr_d     = bus.cmd_addr;
          pwrite_d    = bus.cmd_write;
          pwdata_d    = bus.cmd_write ?
                        bus.cmd_wdata : '0;
          psel_d      = 1'b1;
          penable_d   = 1'b0;
          cmd_ready_d = 1'b0;
          state_d     = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (bus.pready) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_rdata_d = pwrite_q ? '0 : bus.prdata;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else if (TIMEOUT > 0 &&
                     cnt_q == CNT_LAST) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else if (cnt_q != CNT_SAT) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.psel      = psel_q;
  assign bus.penable   = penable_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.paddr     = paddr_q;
  assign bus.pwdata    = pwdata_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_pe_cell_apb_master.sv
// Bench for pe_cell_apb_master: APB slave model,
// transaction-level reference and response scoreboard.
module tb_pe_cell_apb_master;
  import pe_cell_apb_pkg::*;

  localparam int WB = 32;
  localparam int WA = 8;
  localparam int TO = 16;
  localparam int NEVER = 1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;

  always #5 clk = ~clk;

  pe_cell_apb_master_if #(
    .WID_BUS(WB), .WID_ADDR(WA)) bus ();

  pe_cell_apb_master #(
    .WID_BUS(WB), .WID_ADDR(WA), .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .busy(busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  logic [31:0] slv_mem [256];
  logic [31:0] ref_mem [256];
  apb_rsp_t    exp_q [$];
  apb_cmd_t    xfer_q [$];
  apb_cmd_t    cur;
  int  waits = 0;
  int  acc_n = 0;
  int  cyc = 0;
  int  hs_cyc = 0;
  int  xfer_cnt = 0;
  int  rsp_mode = 0;
  bit  late_pready = 0;
  bit  man_rdy = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // APB slave: pready after 'waits' ACCESS cycles.
  always @(negedge clk) begin
    if (bus.psel && bus.penable) begin
      chk("paddr_hold", bus.paddr, cur.addr);
      chk("pwrite_hold", bus.pwrite, cur.write);
      chk("pwdata_hold", bus.pwdata,
          cur.write ? cur.wdata : 32'h0);
      if (acc_n == waits) begin
        bus.pready = 1'b1;
        bus.prdata = slv_mem[bus.paddr];
      end else begin
        bus.pready = 1'b0;
        bus.prdata = $urandom;
      end
      acc_n++;
    end else begin
      bus.pready = late_pready;
      bus.prdata = $urandom;
      acc_n = 0;
    end
  end

  // Completed APB transfers, in order.
  always @(posedge clk) begin
    apb_cmd_t e;
    if (rst_n && bus.psel && bus.penable &&
        bus.pready) begin
      xfer_cnt <= xfer_cnt + 1;
      if (xfer_q.size() == 0) begin
        chk("xfer_unexpected", 1, 0);
      end else begin
        e = xfer_q.pop_front();
        chk("xfer_addr", bus.paddr, e.addr);
        chk("xfer_write", bus.pwrite, e.write);
        if (e.write) begin
          chk("xfer_wdata", bus.pwdata, e.wdata);
          slv_mem[bus.paddr] <= bus.pwdata;
        end
      end
    end
  end

  // Response consumer and scoreboard.
  always @(negedge clk) begin
    apb_rsp_t r;
    if (rsp_mode == 0)
      bus.rsp_ready = 1'b1;
    else if (rsp_mode == 1)
      bus.rsp_ready = 1'($urandom_range(0, 1));
    else
      bus.rsp_ready = man_rdy;
    if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
      hs_cyc = cyc + 1;
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 1, 0);
      end else begin
        r = exp_q.pop_front();
        chk("rsp_err", bus.rsp_err, r.err);
        chk("rsp_rdata", bus.rsp_rdata, r.rdata);
      end
    end
  end

  // Drive one command until accepted; model it.
  task automatic issue(input bit w,
                       input logic [7:0] a,
                       input logic [31:0] d,
                       input int wt,
                       output int acc);
    int n;
    apb_rsp_t r;
    bit err;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    n = 0;
    while (!bus.cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      chk("accept_timeout", 0, 1);
      bus.cmd_valid = 1'b0;
      acc = -1;
      return;
    end
    waits = wt;
    cur.write = w;
    cur.addr  = a;
    cur.wdata = d;
    acc = cyc + 1;
    err = (TO > 0) && (wt >= TO);
    r.err = err;
    r.rdata = (!w && !err) ? ref_mem[a] : 32'h0;
    if (w && !err) ref_mem[a] = d;
    exp_q.push_back(r);
    if (!err) xfer_q.push_back(cur);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'($urandom);
    bus.cmd_addr  = 8'($urandom);
    bus.cmd_wdata = $urandom;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) chk("drain_timeout", 0, 1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_psel"}, bus.psel, 0);
    chk({tag, "_penable"}, bus.penable, 0);
    chk({tag, "_pwrite"}, bus.pwrite, 0);
    chk({tag, "_paddr"}, bus.paddr, 0);
    chk({tag, "_pwdata"}, bus.pwdata, 0);
    chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    chk({tag, "_rsp_err"}, bus.rsp_err, 0);
    chk({tag, "_rsp_rdata"}, bus.rsp_rdata, 0);
    chk({tag, "_cmd_ready"}, bus.cmd_ready, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    int acc, acc2, prev, k, x0;
    bit w;
    logic [7:0] a;
    logic [31:0] v;
    int wt;
    for (int i = 0; i < 256; i++) begin
      v = $urandom;
      slv_mem[i] = v;
      ref_mem[i] = v;
    end
    cur = '0;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;

    // reset state
    repeat (2) @(negedge clk);
    chk_reset_vals("rst");
    rst_n = 1'b1;
    chk("rdy_in_rst", bus.cmd_ready, 0);
    @(negedge clk);
    chk("rdy_after_rst", bus.cmd_ready, 1);

    // write, zero wait, latency
    issue(1, 8'h04, 32'hDEADBEEF, 0, acc);
    @(negedge clk);
    chk("w_psel_n", bus.psel, 1);
    chk("w_pen_n", bus.penable, 0);
    chk("w_pwrite", bus.pwrite, 1);
    chk("w_paddr", bus.paddr, 8'h04);
    chk("w_pwdata", bus.pwdata, 32'hDEADBEEF);
    chk("w_rdy_n", bus.cmd_ready, 0);
    chk("w_busy", busy, 1);
    @(negedge clk);
    chk("w_psel_n1", bus.psel, 1);
    chk("w_pen_n1", bus.penable, 1);
    @(negedge clk);
    chk("w_rspv_n2", bus.rsp_valid, 1);
    chk("w_psel_n2", bus.psel, 0);
    chk("w_pen_n2", bus.penable, 0);
    prev = acc;
    issue(0, 8'h04, 32'h0, 0, acc);
    chk("w_next_gap", acc - prev, 4);
    wait_done();
    chk("w_addr_kept", bus.paddr, 8'h04);

    // read with 3 wait states
    slv_mem[8'h10] = 32'h0000A5A5;
    ref_mem[8'h10] = 32'h0000A5A5;
    issue(0, 8'h10, 32'h0, 3, acc);
    k = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.penable) k++;
    end
    chk("r_pen_cycles", k, 4);
    wait_done();

    // timeout boundary: 15 waits still completes
    issue(0, 8'h20, 32'h0, TO - 1, acc);
    wait_done();

    // timeout abort, late pready ignored
    rsp_mode = 2;
    man_rdy = 1'b0;
    issue(0, 8'h08, 32'h0, NEVER, acc);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.rsp_valid && k < 100);
    chk("to_latency", k, TO + 2);
    chk("to_psel", bus.psel, 0);
    chk("to_err", bus.rsp_err, 1);
    chk("to_rdata", bus.rsp_rdata, 0);
    late_pready = 1'b1;
    repeat (3) @(negedge clk);
    chk("to_late_valid", bus.rsp_valid, 1);
    chk("to_late_err", bus.rsp_err, 1);
    chk("to_late_rdata", bus.rsp_rdata, 0);
    late_pready = 1'b0;
    #1 man_rdy = 1'b1;
    wait_done();
    rsp_mode = 0;
    issue(1, 8'h08, 32'h12345678, 1, acc);
    issue(0, 8'h08, 32'h0, 0, acc);
    wait_done();

    // response backpressure
    rsp_mode = 2;
    man_rdy = 1'b0;
    v = ref_mem[8'h0C];
    issue(0, 8'h0C, 32'h0, 0, acc);
    k = 0;
    while (!bus.rsp_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("bp_valid_seen", bus.rsp_valid, 1);
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          chk("bp_valid", bus.rsp_valid, 1);
          chk("bp_rdata", bus.rsp_rdata, v);
          chk("bp_rdy", bus.cmd_ready, 0);
          @(negedge clk);
        end
        #1 man_rdy = 1'b1;
      end
      issue(1, 8'h0C, 32'hCAFEF00D, 0, acc2);
    join
    chk("bp_accept_after_hs", acc2 - hs_cyc, 1);
    wait_done();
    rsp_mode = 0;

    // back-to-back alternating write/read
    x0 = xfer_cnt;
    prev = 0;
    for (int i = 0; i < 8; i++) begin
      issue(i % 2 == 0, 8'(i * 4), $urandom, 0, acc);
      if (i > 0) chk("b2b_gap", acc - prev, 4);
      prev = acc;
    end
    wait_done();
    chk("b2b_xfers", xfer_cnt - x0, 8);

    // randomized traffic
    rsp_mode = 1;
    for (int i = 0; i < 40; i++) begin
      w = 1'($urandom);
      a = 8'($urandom_range(0, 15) * 4);
      v = $urandom;
      if ($urandom_range(0, 7) == 0)
        wt = TO + $urandom_range(0, 3);
      else if ($urandom_range(0, 7) == 0)
        wt = TO - 1;
      else
        wt = $urandom_range(0, 3);
      issue(w, a, v, wt, acc);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_done();
    rsp_mode = 0;

    // reset during ACCESS wait state
    issue(0, 8'h14, 32'h0, NEVER, acc);
    repeat (5) @(negedge clk);
    chk("mr_busy", busy, 1);
    chk("mr_pen", bus.penable, 1);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("mr");
    exp_q.delete();
    xfer_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("mr_rdy_rel", bus.cmd_ready, 1);
    chk("mr_no_rsp", bus.rsp_valid, 0);
    repeat (3) begin
      @(negedge clk);
      chk("mr_no_stale", bus.rsp_valid, 0);
    end
    issue(0, 8'h14, 32'h0, 0, acc);
    wait_done();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
